// File: rtl/mult_seq_param.sv
// mult_seq_param: digit-serial WIDTH x WIDTH -> 2*WIDTH multiplier.
// Each step multiplies one DIGIT-bit digit of |a| by one digit of |b|,
// shifts the sub-product to its position and accumulates it. In signed
// mode the magnitudes are multiplied and the sign is applied in FINISH.
module mult_seq_param #(
  parameter int WIDTH = 8,  // operand width, multiple of DIGIT, >= 2*DIGIT
  parameter int DIGIT = 2   // bits per digit of the sub-multiplier
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
  output logic                 busy,
  output logic                 done_flag,
  output logic [2*WIDTH-1:0]   product_out
);

  localparam int K     = WIDTH / DIGIT;
  localparam int STEPS = K * K;
  localparam int IDXW  = $clog2(STEPS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag;
  logic               neg;
  logic [2*WIDTH-1:0] acc;
  logic [IDXW-1:0]    idx;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [IDXW-1:0]    dig_i;
  logic [IDXW-1:0]    dig_j;
  logic [DIGIT-1:0]   a_dig;
  logic [DIGIT-1:0]   b_dig;
  logic [2*DIGIT-1:0] sub_prod;
  logic [2*WIDTH-1:0] addend;

  assign busy = (state != ST_IDLE);

  // Operand magnitudes; the most negative value negates onto itself,
  // which read as unsigned is exactly 2^(WIDTH-1).
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    a_abs = (signed_mode && dataa[WIDTH-1]) ? -dataa : dataa;
    b_abs = (signed_mode && datab[WIDTH-1]) ? -datab : datab;
  end

  // Select digit pair (idx / K, idx % K) and form the shifted sub-product.
  always_comb begin
    dig_i    = idx / IDXW'(K);
    dig_j    = idx % IDXW'(K);
    a_dig    = DIGIT'(amag >> (dig_i * DIGIT));
    b_dig    = DIGIT'(bmag >> (dig_j * DIGIT));
    sub_prod = (2*DIGIT)'(a_dig) * (2*DIGIT)'(b_dig);
    addend   = (2*WIDTH)'(sub_prod) << ((dig_i + dig_j) * DIGIT);
  end

  // Control FSM, datapath registers and the held result; ena freezes all.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      amag        <= '0;
      bmag        <= '0;
      neg         <= 1'b0;
      acc         <= '0;
      idx         <= '0;
      done_flag   <= 1'b0;
      product_out <= '0;
    end else if (ena) begin
      done_flag <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            amag  <= a_abs;
            bmag  <= b_abs;
            neg   <= signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
            acc   <= '0;
            idx   <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc <= acc + addend;
          idx <= idx + 1'b1;
          if (idx == IDXW'(STEPS - 1)) state <= ST_FINISH;
        end
        ST_FINISH: begin
          product_out <= neg ? -acc : acc;
          done_flag   <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
